// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one pipelined-Wishbone-style memory port between the fetch
// stage and the load/store stage. Data has priority, one access is outstanding at a time,
// an in-flight fetch can be flushed, and a hung access is aborted with o_bus_err.
//
// Optional build macro ARB_FAIRNESS_EN: after MAX_DATA_BURST consecutive data grants made
// while a fetch is waiting, the next grant goes to the fetch. Without the macro data
// priority is strict and the burst counter does not exist.
module rv32i_mem_arbiter #(
  parameter int unsigned TIMEOUT        = 16,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // Fetch requester
  input  logic        i_ireq,
  input  logic [31:0] i_iaddr,
  output logic        o_iack,
  output logic [31:0] o_inst,
  input  logic        i_flush,
  // Data requester
  input  logic        i_dreq,
  input  logic        i_dwe,
  input  logic [31:0] i_daddr,
  input  logic [31:0] i_dwdata,
  input  logic [3:0]  i_dsel,
  output logic        o_dack,
  output logic [31:0] o_drdata,
  output logic        o_bus_err,
  // Memory port
  output logic        o_mem_cyc,
  output logic        o_mem_stb,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_sel,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  // Wait-state count at which an unacknowledged access is abandoned.
  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT - 1);

  // Out-of-range parameters stop elaboration.
  if (TIMEOUT < 2 || TIMEOUT > 255 || MAX_DATA_BURST < 1 || MAX_DATA_BURST > 7)
  begin : g_param_check
    $error("rv32i_mem_arbiter: TIMEOUT or MAX_DATA_BURST out of range");
  end

  typedef enum logic [1:0] {
    StIdle,
    StIWait,
    StDWait
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        discard_q, discard_d;
  logic        mem_cyc_q, mem_cyc_d;
  logic        mem_stb_q, mem_stb_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_sel_q, mem_sel_d;
  logic        iack_q, iack_d;
  logic        dack_q, dack_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] drdata_q, drdata_d;

  logic        force_fetch;
  logic        grant_data;
  logic        grant_fetch;
  logic        fetch_discard;

`ifdef ARB_FAIRNESS_EN
  localparam logic [2:0] BurstLim = 3'(MAX_DATA_BURST);
  logic [2:0] burst_q, burst_d;
`endif

  // A flush seen in the ack cycle itself must also suppress the fetch response.
  assign fetch_discard = discard_q | i_flush;

  // Arbitration between the two requesters, evaluated only while idle.
  always_comb begin
    force_fetch = 1'b0;
`ifdef ARB_FAIRNESS_EN
    force_fetch = (burst_q >= BurstLim) && i_ireq && !i_flush;
`endif
    grant_data  = (state_q == StIdle) && i_dreq && !force_fetch;
    grant_fetch = (state_q == StIdle) && !grant_data && i_ireq && !i_flush;
  end

`ifdef ARB_FAIRNESS_EN
  // Consecutive data grants made while a fetch is waiting; saturates.
  always_comb begin
    burst_d = burst_q;
    if (grant_fetch) begin
      burst_d = 3'd0;
    end else if (grant_data) begin
      if (!i_ireq) begin
        burst_d = 3'd0;
      end else if (burst_q != 3'd7) begin
        burst_d = burst_q + 3'd1;
      end
    end
  end

  // Burst counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      burst_q <= 3'd0;
    end else begin
      burst_q <= burst_d;
    end
  end
`endif

  // Next-state, bus-side and response-side logic of the access FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    mem_cyc_d   = mem_cyc_q;
    mem_stb_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;
    iack_d      = 1'b0;
    dack_d      = 1'b0;
    bus_err_d   = 1'b0;
    inst_d      = inst_q;
    drdata_d    = drdata_q;

    case (state_q)
      StIdle: begin
        if (grant_data) begin
          mem_addr_d  = i_daddr;
          mem_we_d    = i_dwe;
          mem_wdata_d = i_dwdata;
          mem_sel_d   = i_dsel;
          mem_cyc_d   = 1'b1;
          mem_stb_d   = 1'b1;
          cnt_d       = 8'd0;
          state_d     = StDWait;
        end else if (grant_fetch) begin
          mem_addr_d  = i_iaddr;
          mem_we_d    = 1'b0;
          mem_wdata_d = 32'd0;
          mem_sel_d   = 4'hF;
          mem_cyc_d   = 1'b1;
          mem_stb_d   = 1'b1;
          cnt_d       = 8'd0;
          discard_d   = 1'b0;
          state_d     = StIWait;
        end
      end

      StIWait, StDWait: begin
        if (state_q == StIWait && i_flush) begin
          discard_d = 1'b1;
        end
        // An ack in the same cycle as the limit is a normal completion.
        if (i_mem_ack) begin
          mem_cyc_d = 1'b0;
          state_d   = StIdle;
          if (state_q == StDWait) begin
            dack_d   = 1'b1;
            drdata_d = i_mem_rdata;
          end else if (!fetch_discard) begin
            iack_d = 1'b1;
            inst_d = i_mem_rdata;
          end
        end else if (cnt_q == TimeoutLim) begin
          mem_cyc_d = 1'b0;
          state_d   = StIdle;
          if (state_q == StDWait) begin
            dack_d    = 1'b1;
            drdata_d  = 32'd0;
            bus_err_d = 1'b1;
          end else if (!fetch_discard) begin
            iack_d    = 1'b1;
            inst_d    = 32'd0;
            bus_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d   = StIdle;
        mem_cyc_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      discard_q   <= 1'b0;
      mem_cyc_q   <= 1'b0;
      mem_stb_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_sel_q   <= 4'd0;
      iack_q      <= 1'b0;
      dack_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      inst_q      <= 32'd0;
      drdata_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
      mem_cyc_q   <= mem_cyc_d;
      mem_stb_q   <= mem_stb_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
      iack_q      <= iack_d;
      dack_q      <= dack_d;
      bus_err_q   <= bus_err_d;
      inst_q      <= inst_d;
      drdata_q    <= drdata_d;
    end
  end

  assign o_iack      = iack_q;
  assign o_inst      = inst_q;
  assign o_dack      = dack_q;
  assign o_drdata    = drdata_q;
  assign o_bus_err   = bus_err_q;
  assign o_mem_cyc   = mem_cyc_q;
  assign o_mem_stb   = mem_stb_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_sel   = mem_sel_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level model (grant cycle -> strobe, planned wait -> response cycle).
module tb_rv32i_mem_arbiter;

  localparam int TIMEOUT        = 16;
  localparam int MAX_DATA_BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_ireq, i_flush, i_dreq, i_dwe, i_mem_ack;
  logic [31:0] i_iaddr, i_daddr, i_dwdata, i_mem_rdata;
  logic [3:0]  i_dsel;
  logic        o_iack, o_dack, o_bus_err, o_mem_cyc, o_mem_stb, o_mem_we;
  logic [31:0] o_inst, o_drdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_sel;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(
    .TIMEOUT        (TIMEOUT),
    .MAX_DATA_BURST (MAX_DATA_BURST)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ireq      (i_ireq),
    .i_iaddr     (i_iaddr),
    .o_iack      (o_iack),
    .o_inst      (o_inst),
    .i_flush     (i_flush),
    .i_dreq      (i_dreq),
    .i_dwe       (i_dwe),
    .i_daddr     (i_daddr),
    .i_dwdata    (i_dwdata),
    .i_dsel      (i_dsel),
    .o_dack      (o_dack),
    .o_drdata    (o_drdata),
    .o_bus_err   (o_bus_err),
    .o_mem_cyc   (o_mem_cyc),
    .o_mem_stb   (o_mem_stb),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_sel   (o_mem_sel),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n    = 0;

  // Model of the single outstanding access.
  bit          m_busy = 1'b0;
  bit          m_own_d, m_we, m_timeout, m_silent;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_sel;
  int          m_strobe, m_resp, m_k;
  int          m_burst = 0;
  int          late_ack_cycle = -1;
  int          plan_k[$];
  logic [31:0] plan_rdata[$];

  // Requester behaviour.
  bit auto_i = 1'b0, auto_d = 1'b0;
  bit i_active = 1'b0, d_active = 1'b0;
  int d_rate = 40;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_iack"}, 32'(o_iack), 32'd0);
    check_val({tag, "_dack"}, 32'(o_dack), 32'd0);
    check_val({tag, "_err"}, 32'(o_bus_err), 32'd0);
    check_val({tag, "_cyc"}, 32'(o_mem_cyc), 32'd0);
    check_val({tag, "_stb"}, 32'(o_mem_stb), 32'd0);
    check_val({tag, "_we"}, 32'(o_mem_we), 32'd0);
    check_val({tag, "_addr"}, o_mem_addr, 32'd0);
    check_val({tag, "_wdata"}, o_mem_wdata, 32'd0);
    check_val({tag, "_sel"}, 32'(o_mem_sel), 32'd0);
    check_val({tag, "_inst"}, o_inst, 32'd0);
    check_val({tag, "_drdata"}, o_drdata, 32'd0);
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(99));
    if (r < 55) return 0;
    if (r < 85) return int'($urandom_range(3, 1));
    return int'($urandom_range(17, 13));
  endfunction

  task automatic new_data_req();
    d_active = 1'b1;
    i_dwe    = 1'($urandom_range(1));
    i_daddr  = $urandom();
    i_dwdata = $urandom();
    i_dsel   = 4'($urandom_range(15));
  endtask

  // Record a grant made at the current cycle; strobe follows next cycle.
  task automatic start_access(input bit is_data);
    m_busy   = 1'b1;
    m_own_d  = is_data;
    m_addr   = is_data ? i_daddr : i_iaddr;
    m_we     = is_data ? i_dwe : 1'b0;
    m_wdata  = i_dwdata;
    m_sel    = is_data ? i_dsel : 4'hF;
    m_strobe = cyc_n + 1;
    m_silent = 1'b0;
    if (plan_k.size() > 0) begin
      m_k     = plan_k.pop_front();
      m_rdata = plan_rdata.pop_front();
    end else begin
      m_k     = rand_wait();
      m_rdata = $urandom();
    end
    m_timeout = (m_k >= TIMEOUT);
    m_resp    = m_timeout ? m_strobe + TIMEOUT : m_strobe + m_k + 1;
    if (m_timeout) late_ack_cycle = m_resp;
    if (is_data) m_burst = i_ireq ? ((m_burst < 7) ? m_burst + 1 : 7) : 0;
    else         m_burst = 0;
  endtask

  // First half of a cycle: memory responder and requesters drive inputs.
  task automatic begin_cycle();
    bit resp_i, resp_d;
    @(posedge clk);
    cyc_n++;
    #1;
    i_mem_ack   = 1'b0;
    i_mem_rdata = $urandom();
    if (m_busy && !m_timeout && cyc_n == m_strobe + m_k) begin
      i_mem_ack   = 1'b1;
      i_mem_rdata = m_rdata;
    end
    if (cyc_n == late_ack_cycle) i_mem_ack = 1'b1;
    resp_i  = m_busy && cyc_n == m_resp && !m_own_d && !m_silent;
    resp_d  = m_busy && cyc_n == m_resp && m_own_d;
    i_flush = 1'b0;
    if (resp_d) d_active = 1'b0;
    if (resp_i) i_active = 1'b0;
    if (!d_active && auto_d && int'($urandom_range(99)) < d_rate) new_data_req();
    if (!i_active && auto_i && $urandom_range(99) < 60) begin
      i_active = 1'b1;
      i_iaddr  = $urandom() & 32'hFFFF_FFFC;
    end else if (i_active && auto_i && $urandom_range(99) < 5) begin
      i_flush = 1'b1;
      i_iaddr = $urandom() & 32'hFFFF_FFFC;
    end
    i_dreq = d_active;
    i_ireq = i_active;
  endtask

  // Second half: compare outputs with the model, then apply this cycle's arbitration.
  task automatic end_cycle();
    bit exp_ack, exp_iack, exp_dack, exp_stb, exp_cyc, force_fetch;
    @(negedge clk);
    if (!rst_n) begin
      check_reset_outs("reset");
      m_busy = 1'b0; m_burst = 0; late_ack_cycle = -1;
      i_active = 1'b0; d_active = 1'b0;
      return;
    end
    exp_ack  = m_busy && cyc_n == m_resp;
    exp_iack = exp_ack && !m_own_d && !m_silent;
    exp_dack = exp_ack && m_own_d;
    exp_stb  = m_busy && cyc_n == m_strobe;
    exp_cyc  = m_busy && cyc_n >= m_strobe && cyc_n < m_resp;
    check_val("iack", 32'(o_iack), 32'(exp_iack));
    check_val("dack", 32'(o_dack), 32'(exp_dack));
    check_val("bus_err", 32'(o_bus_err), 32'((exp_iack || exp_dack) && m_timeout));
    check_val("mem_stb", 32'(o_mem_stb), 32'(exp_stb));
    check_val("mem_cyc", 32'(o_mem_cyc), 32'(exp_cyc));
    if (exp_iack) check_val("inst", o_inst, m_timeout ? 32'd0 : m_rdata);
    if (exp_dack) check_val("drdata", o_drdata, m_timeout ? 32'd0 : m_rdata);
    if (exp_cyc) begin
      check_val("mem_addr", o_mem_addr, m_addr);
      check_val("mem_we", 32'(o_mem_we), 32'(m_we));
      check_val("mem_sel", 32'(o_mem_sel), 32'(m_sel));
      if (m_own_d) check_val("mem_wdata", o_mem_wdata, m_wdata);
    end
    if (m_busy && !m_own_d && i_flush && cyc_n >= m_strobe && cyc_n < m_resp) m_silent = 1'b1;
    if (!m_busy || cyc_n >= m_resp) begin
      m_busy      = 1'b0;
      force_fetch = 1'b0;
`ifdef ARB_FAIRNESS_EN
      force_fetch = (m_burst >= MAX_DATA_BURST) && i_ireq && !i_flush;
`endif
      if (i_dreq && !force_fetch)  start_access(1'b1);
      else if (i_ireq && !i_flush) start_access(1'b0);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      end_cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {i_ireq, i_flush, i_dreq, i_dwe, i_mem_ack} = '0;
    {i_iaddr, i_daddr, i_dwdata, i_mem_rdata} = '0;
    i_dsel = 4'd0;

    run_cycles(3);
    begin_cycle(); rst_n = 1'b1; end_cycle();
    run_cycles(2);

    // Fetch alone, zero wait states.
    plan_k.push_back(0); plan_rdata.push_back(32'h0050_0093);
    begin_cycle(); i_active = 1'b1; i_iaddr = 32'h100; i_ireq = 1'b1; end_cycle();
    run_cycles(4);

    // Simultaneous requests: data write goes first.
    plan_k.push_back(1); plan_rdata.push_back(32'h1111_2222);
    plan_k.push_back(2); plan_rdata.push_back(32'h3333_4444);
    begin_cycle();
    d_active = 1'b1; i_dwe = 1'b1; i_daddr = 32'h2000; i_dwdata = 32'hDEAD_BEEF;
    i_dsel = 4'b0011; i_dreq = 1'b1;
    i_active = 1'b1; i_iaddr = 32'h104; i_ireq = 1'b1;
    end_cycle();
    run_cycles(10);

    // Flush during the wait of a fetch to 0x40, then redirect to 0x80.
    plan_k.push_back(3); plan_rdata.push_back(32'h0400_0013);
    plan_k.push_back(0); plan_rdata.push_back(32'h0800_0013);
    begin_cycle(); i_active = 1'b1; i_iaddr = 32'h40; i_ireq = 1'b1; end_cycle();
    run_cycles(1);
    begin_cycle(); i_flush = 1'b1; i_iaddr = 32'h80; end_cycle();
    run_cycles(10);

    // Data read to 0x3000 never acknowledged; late ack after the abort.
    plan_k.push_back(TIMEOUT); plan_rdata.push_back(32'hBAD0_BAD0);
    begin_cycle();
    d_active = 1'b1; i_dwe = 1'b0; i_daddr = 32'h3000; i_dsel = 4'hF; i_dreq = 1'b1;
    end_cycle();
    run_cycles(22);

    // Reset in the middle of a data access.
    plan_k.push_back(20); plan_rdata.push_back(32'h5555_AAAA);
    begin_cycle();
    d_active = 1'b1; i_dwe = 1'b0; i_daddr = 32'h3100; i_dsel = 4'hF; i_dreq = 1'b1;
    end_cycle();
    run_cycles(3);
    begin_cycle();
    rst_n = 1'b0; d_active = 1'b0; i_dreq = 1'b0;
    #1;
    check_reset_outs("rst_async");
    end_cycle();
    run_cycles(1);
    begin_cycle(); rst_n = 1'b1; end_cycle();
    begin_cycle(); i_mem_ack = 1'b1; end_cycle();
    plan_k.push_back(0); plan_rdata.push_back(32'h0000_0297);
    begin_cycle(); i_active = 1'b1; i_iaddr = 32'h0; i_ireq = 1'b1; end_cycle();
    run_cycles(5);

    // Continuous data traffic with a fetch waiting.
    auto_d = 1'b1; d_rate = 100;
    begin_cycle(); i_active = 1'b1; i_iaddr = 32'h200; i_ireq = 1'b1; end_cycle();
    run_cycles(60);
    auto_d = 1'b0;
    run_cycles(60);

    // Random mixed traffic.
    auto_d = 1'b1; auto_i = 1'b1; d_rate = 40;
    run_cycles(3000);
    auto_d = 1'b0; auto_i = 1'b0;
    run_cycles(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
- Shares one pipelined-Wishbone-style memory port between the instruction-fetch requester (fetch stage) and the data requester (load/store stage).
- Sits between the core pipeline and the unified memory. Serialises accesses, returns read data and acknowledges to the owning requester, supports flushing an in-flight fetch, and times out hung accesses.

Parameters:
- TIMEOUT, 16: wait-state cycles allowed after a strobe before the access is aborted with an error; legal range 2..255.
- MAX_DATA_BURST, 4: consecutive data grants allowed while a fetch is pending; only used with ARB_FAIRNESS_EN.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_ireq  in  1  fetch read request (level)
- i_iaddr  in  32  fetch address, word aligned
- o_iack  out  1  fetch complete pulse
- o_inst  out  32  fetched word, valid while o_iack=1
- i_flush  in  1  discard in-flight or pending fetch
- i_dreq  in  1  data request (level)
- i_dwe  in  1  1=write, 0=read
- i_daddr  in  32  data address
- i_dwdata  in  32  write data
- i_dsel  in  4  byte-lane select
- o_dack  out  1  data complete pulse
- o_drdata  out  32  read data, valid while o_dack=1
- o_bus_err  out  1  qualifies o_iack/o_dack: access timed out
- o_mem_cyc  out  1  bus cycle active
- o_mem_stb  out  1  request strobe, one cycle per access
- o_mem_we  out  1  write enable
- o_mem_addr  out  32  bus address
- o_mem_wdata  out  32  bus write data
- o_mem_sel  out  4  bus byte select; 4'hF for fetches
- i_mem_ack  in  1  bus acknowledge
- i_mem_rdata  in  32  bus read data

Behaviour:
- Reset: i_rst_n, asynchronous, active-low; clock i_clk.
- During reset, all outputs are 0. State is IDLE and all counters are 0.
- Reset asserted mid-access abandons the access immediately. A later i_mem_ack is ignored.
- FSM states are IDLE, I_WAIT and D_WAIT.
- IDLE:
  - i_dreq=1: grant data. Data has strict priority when both requests are high.
  - Else i_ireq=1 and i_flush=0: grant fetch.
  - On a grant, register the address, we, wdata and sel onto the bus outputs. Assert o_mem_cyc=1 and o_mem_stb=1 next cycle, then enter the matching WAIT state.
- WAIT states:
  - o_mem_stb=1 for the first cycle only.
  - o_mem_cyc is held until ack or timeout.
  - Bus outputs stay stable.
- i_mem_ack in WAIT, same cycle:
  - Drop o_mem_cyc next cycle.
  - Register i_mem_rdata into o_inst or o_drdata.
  - Pulse o_iack or o_dack for exactly 1 cycle with o_bus_err=0.
  - Return to IDLE.
- Latency: request sampled in cycle N; strobe in N+1; ack in N+1+k (k≥0); response pulse in N+2+k. Minimum round trip is 2 cycles.
- Back-to-back: the requester drops its req in the cycle its ack is high if it wants no further access. If req is still high in that cycle it is a new request, sampled in IDLE.
- Requester holds addr and data stable from raising req until its ack.
- Flush:
  - i_flush in I_WAIT sets a discard flag. The bus access still completes normally, but o_iack is suppressed.
  - i_flush in IDLE blocks a fetch grant that cycle.
  - Data accesses are unaffected by flush.
- Timeout:
  - An 8-bit counter clears on strobe and increments each WAIT cycle without ack.
  - When the counter reaches TIMEOUT-1 without ack, drop o_mem_cyc and pulse the owner's ack with o_bus_err=1 and read data 0. Then return to IDLE.
  - A flushed fetch that times out stays silent.
- Stray i_mem_ack in IDLE is ignored.
- Ack in the same cycle the counter hits its limit counts as a normal ack; ack wins.
- At most one access is outstanding at any time.

Optional Feature:
- ARB_FAIRNESS_EN defined:
  - A 3-bit counter counts consecutive data grants made while i_ireq=1.
  - At MAX_DATA_BURST, the next IDLE grant goes to fetch even if i_dreq=1.
  - The counter clears on any fetch grant, and whenever i_ireq=0 at a data grant.
- Not defined: strict data priority; the counter logic is absent.

Test Plan:
- Fetch alone: i_ireq=1, i_iaddr=0x100, ack 0 wait states, rdata=0x00500093 -> o_mem_stb in cycle 1 with addr 0x100 and sel F; o_iack=1 and o_inst=0x00500093 in cycle 2.
- Simultaneous requests: i_ireq=1 and i_dreq=1 write to 0x2000, wdata 0xDEADBEEF, sel 4'b0011 -> data strobe first, o_mem_we=1; after o_dack the fetch strobes; no overlap of o_mem_cyc.
- Flush in flight: fetch 0x40 with ack after 3 waits, i_flush pulsed in wait cycle 1 -> bus cycle completes, o_iack stays 0; next fetch 0x80 proceeds normally.
- Timeout: data read to 0x3000, no ack, TIMEOUT=16 -> o_dack=1 with o_bus_err=1 and o_drdata=0 on the 16th wait-state cycle after the strobe (counter at 15); a late i_mem_ack is ignored.
- Reset mid-access: i_rst_n low during D_WAIT -> all outputs 0 immediately; after release, first fetch issues at PC 0x0 correctly.
- ARB_FAIRNESS_EN with MAX_DATA_BURST=4: i_dreq and i_ireq held high -> 4 data grants, then 1 fetch grant, repeating; without the macro, fetch never granted.
